// File: rtl/uart_calc_pkg.sv
// Shared constants and types for the UART calculator (ASCII codes, calculator state, operator).
package uart_calc_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_U     = 8'h55;
  localparam logic [7:0] CH_S     = 8'h53;

  typedef enum logic {S_A, S_B} calc_state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return CH_0 + {4'd0, d};
  endfunction

endpackage

// File: rtl/uart_calc_tx.sv
// 8N1 serial transmitter; ready rises in the last stop-bit cycle so frames run back to back.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       tx_valid,
  output logic       ready
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [9:0]    shreg;
  logic [3:0]    bitn;
  logic [CW-1:0] cnt;
  logic          active;
  logic          bit_end;

  assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign ready    = !active || (bitn == 4'd9 && bit_end);
  assign txd      = active ? shreg[0] : 1'b1;
  assign tx_valid = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      shreg  <= '1;
      bitn   <= '0;
      cnt    <= '0;
    end else if (start && ready) begin
      shreg  <= {1'b1, data, 1'b0};
      active <= 1'b1;
      bitn   <= '0;
      cnt    <= '0;
    end else if (active) begin
      if (bit_end) begin
        cnt <= '0;
        if (bitn == 4'd9) begin
          active <= 1'b0;
        end else begin
          bitn  <= bitn + 4'd1;
          shreg <= {1'b1, shreg[9:1]};
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_calc_top.sv
// UART ASCII calculator top: receiver, calculator FSM, decimal converter, tx queue.
// Define ECHO_EN to queue every received character for transmission ahead of its response.
module uart_calc_top
  import uart_calc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_DIGITS   = 4,
  parameter int TXQ_DEPTH    = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rxd,
  input  logic rx_start,
  output logic txd,
  output logic tx_valid
);
  localparam int RCW = $clog2(CLKS_PER_BIT + CLKS_PER_BIT / 2);
  localparam int DW  = $clog2(MAX_DIGITS + 1);
  localparam int QAW = $clog2(TXQ_DEPTH);

  // ---------------- receiver ----------------
  logic           rx_armed, rx_busy, char_stb;
  logic [RCW-1:0] rx_cnt;
  logic [2:0]     rx_bitn;
  logic [7:0]     rx_char;

  always_ff @(posedge clk) begin
    char_stb <= 1'b0;
    if (n_rst) begin
      rx_armed <= 1'b0;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bitn  <= '0;
      rx_char  <= '0;
    end else if (!rx_busy) begin
      if (rx_start) begin
        rx_armed <= 1'b1;
      end else if (rx_armed && !rxd) begin
        // first wait reaches mid bit 0: one and a half bit times past the start edge
        rx_busy <= 1'b1;
        rx_cnt  <= RCW'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1);
        rx_bitn <= '0;
      end
    end else if (rx_cnt == '0) begin
      rx_char <= {rxd, rx_char[7:1]};
      rx_cnt  <= RCW'(CLKS_PER_BIT - 1);
      rx_bitn <= rx_bitn + 3'd1;
      if (rx_bitn == 3'd7) begin
        rx_busy  <= 1'b0;
        rx_armed <= 1'b0;
        char_stb <= 1'b1;
      end
    end else begin
      rx_cnt <= rx_cnt - RCW'(1);
    end
  end

  // ---------------- calculator FSM ----------------
  calc_state_e   state, state_n;
  op_e           op, op_n;
  logic [31:0]   a, b, a_n, b_n, res, mag;
  logic [DW-1:0] a_dig, b_dig, a_dig_n, b_dig_n;
  logic          load_us, load_res, clear, neg;
  logic [31:0]   digit;

  assign digit = {28'd0, rx_char[3:0]};

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= S_A;
      op    <= OP_ADD;
      a     <= '0;
      b     <= '0;
      a_dig <= '0;
      b_dig <= '0;
    end else begin
      state <= state_n;
      op    <= op_n;
      a     <= a_n;
      b     <= b_n;
      a_dig <= a_dig_n;
      b_dig <= b_dig_n;
    end
  end

  always_comb begin
    state_n  = state;
    op_n     = op;
    a_n      = a;
    b_n      = b;
    a_dig_n  = a_dig;
    b_dig_n  = b_dig;
    load_us  = 1'b0;
    load_res = 1'b0;
    clear    = 1'b0;
    if (char_stb) begin
      if (rx_char >= CH_0 && rx_char <= CH_9) begin
        if (state == S_A) begin
          if (a_dig != DW'(MAX_DIGITS)) begin
            a_n     = a * 32'd10 + digit;
            a_dig_n = a_dig + DW'(1);
          end
        end else if (b_dig != DW'(MAX_DIGITS)) begin
          b_n     = b * 32'd10 + digit;
          b_dig_n = b_dig + DW'(1);
        end
      end else begin
        case (rx_char)
          CH_PLUS, CH_MINUS, CH_MUL, CH_DIV: begin
            if (state == S_A) begin
              state_n = S_B;
              case (rx_char)
                CH_MINUS: op_n = OP_SUB;
                CH_MUL:   op_n = OP_MUL;
                CH_DIV:   op_n = OP_DIV;
                default:  op_n = OP_ADD;
              endcase
            end else begin
              load_us = 1'b1;
              clear   = 1'b1;
            end
          end
          CH_EQ: begin
            clear = 1'b1;
            if (state == S_B && !(op == OP_DIV && b == '0)) load_res = 1'b1;
            else                                            load_us  = 1'b1;
          end
          CH_SP: ;
          CH_I:  clear = 1'b1;
          default: begin
            load_us = 1'b1;
            clear   = 1'b1;
          end
        endcase
      end
      if (clear) begin
        state_n = S_A;
        op_n    = OP_ADD;
        a_n     = '0;
        b_n     = '0;
        a_dig_n = '0;
        b_dig_n = '0;
      end
    end
  end

  always_comb begin
    case (op)
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_DIV:  res = (b == '0) ? '0 : a / b;
      default: res = a + b;
    endcase
    neg = res[31];
    mag = neg ? (~res + 32'd1) : res;
  end

  // ---------------- response stack / decimal converter ----------------
  // Digits are produced LS first onto a stack, so popping yields sign then MS digit first.
  logic [7:0]  stk [16];
  logic [3:0]  sp;
  logic        cnv_busy, cnv_neg, echo_push, seq_pop;
  logic [31:0] cnv_mag;

`ifdef ECHO_EN
  assign echo_push = char_stb;
`else
  assign echo_push = 1'b0;
`endif

  assign seq_pop = (sp != 4'd0) && !cnv_busy && !echo_push;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      cnv_busy <= 1'b0;
      cnv_neg  <= 1'b0;
      cnv_mag  <= '0;
      sp       <= '0;
    end else if (load_res) begin
      cnv_busy <= 1'b1;
      cnv_mag  <= mag;
      cnv_neg  <= neg;
      sp       <= '0;
    end else if (load_us) begin
      stk[1] <= CH_U;
      stk[0] <= CH_S;
      sp     <= 4'd2;
    end else if (cnv_busy) begin
      stk[sp] <= to_ascii(4'(cnv_mag % 32'd10));
      cnv_mag <= cnv_mag / 32'd10;
      sp      <= sp + 4'd1;
      if (cnv_mag < 32'd10) begin
        cnv_busy <= 1'b0;
        if (cnv_neg) begin
          stk[sp + 4'd1] <= CH_MINUS;
          sp             <= sp + 4'd2;
        end
      end
    end else if (seq_pop) begin
      sp <= sp - 4'd1;
    end
  end

  // ---------------- tx queue ----------------
  logic [7:0] q [TXQ_DEPTH];
  logic [QAW:0] wptr, rptr;
  logic       q_push, q_pop, q_full, q_empty, tx_ready;
  logic [7:0] q_din;

  assign q_push  = echo_push || seq_pop;
  assign q_din   = echo_push ? rx_char : stk[sp - 4'd1];
  assign q_empty = (wptr == rptr);
  assign q_full  = (wptr[QAW] != rptr[QAW]) && (wptr[QAW-1:0] == rptr[QAW-1:0]);
  assign q_pop   = !q_empty && tx_ready;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (q_push && !q_full) begin
        q[wptr[QAW-1:0]] <= q_din;
        wptr             <= wptr + (QAW+1)'(1);
      end
      if (q_pop) rptr <= rptr + (QAW+1)'(1);
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (n_rst),
    .start    (q_pop),
    .data     (q[rptr[QAW-1:0]]),
    .txd      (txd),
    .tx_valid (tx_valid),
    .ready    (tx_ready)
  );

endmodule

// File: tb/tb_uart_calc_top.sv
// Scoreboard bench for uart_calc_top: expected tx characters are queued, a monitor decodes txd frames.
module tb_uart_calc_top;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic rxd = 1'b1;
  logic rx_start = 1'b0;
  logic txd, tx_valid;

  byte unsigned exp_q[$];
  int passed = 0;
  int total = 0;
  int vcnt = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_calc_top #(.CLKS_PER_BIT(CPB), .MAX_DIGITS(4), .TXQ_DEPTH(16)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .rxd      (rxd),
    .rx_start (rx_start),
    .txd      (txd),
    .tx_valid (tx_valid)
  );

  always @(negedge clk) if (tx_valid) vcnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input bit log_echo);
`ifdef ECHO_EN
    if (log_echo) exp_q.push_back(c);
`endif
    rx_start = 1'b1;
    tick(1);
    rx_start = 1'b0;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = c[i];
      tick(CPB);
    end
    rxd = 1'b1;
    tick(CPB);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic monitor();
    logic [7:0] ch;
    logic stop;
    forever begin
      @(negedge clk);
      if (mon_en && tx_valid && !txd) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          ch[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        stop = txd;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL tx_unexpected: got %02h required no character", ch);
        end else begin
          check("tx_char", {24'd0, ch}, {24'd0, exp_q.pop_front()});
        end
        check("tx_stop_bit", {31'd0, stop}, 32'd1);
        repeat (CPB / 2 - 1) @(negedge clk);
      end
    end
  endtask

  initial begin
    int v0;
    fork
      monitor();
    join_none

    tick(3);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    n_rst = 1'b0;
    tick(2);

    // reset in the middle of a transmitted frame
    send_char(8'h3D, 1'b0);
    for (int i = 0; i < 2000 && !tx_valid; i++) tick(1);
    check("tx_started_before_reset", {31'd0, tx_valid}, 32'd1);
    tick(40);
    n_rst = 1'b1;
    tick(1);
    check("midframe_reset_txd", {31'd0, txd}, 32'd1);
    check("midframe_reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    n_rst = 1'b0;
    v0 = vcnt;
    tick(400);
    check("queue_empty_after_reset", vcnt - v0, 32'd0);
    mon_en = 1'b1;

    v0 = vcnt;
    send_char(8'h49, 1'b1);
    tick(200);
`ifdef ECHO_EN
    check("I_frame_valid_cycles", vcnt - v0, 32'(10 * CPB));
`else
    check("I_frame_valid_cycles", vcnt - v0, 32'd0);
`endif

    send_str("12+34=");    expect_str("46");
    send_str("7-9=");      expect_str("-2");
    send_str("25*4=");     expect_str("100");
    send_str("8/0=");      expect_str("US");
    send_str("=");         expect_str("US");
    send_str("12345+1=");  expect_str("1235");
    send_str("5 * 3=");    expect_str("15");
    send_str("X");         expect_str("US");
    send_str("0-0=");      expect_str("0");

    for (int i = 0; i < 20000 && (exp_q.size() != 0 || tx_valid); i++) tick(1);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    tick(300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
